// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests,
// buffers returned words and presents {pc, instr} pairs to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_valid,
    input  logic        fs_ready,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_instr
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] pcq_rd_q, pcq_rd_d;
    logic [PTR_W-1:0] pcq_wr_q, pcq_wr_d;

    logic [31:0] buf_pc_q    [BUF_DEPTH];
    logic [31:0] buf_instr_q [BUF_DEPTH];
    logic [31:0] pcq_q       [BUF_DEPTH];

    logic fire;
    logic drop;
    logic push;
    logic pop;
    logic credit_ok;
    logic buf_empty;

    // Handshake outputs, FSM and all counter/pointer next-state
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        pcq_rd_d   = pcq_rd_q;
        pcq_wr_d   = pcq_wr_q;

        buf_empty = (cnt_q == '0);
        credit_ok = (32'(out_q) + 32'(cnt_q)) < BUF_DEPTH;

        imem_req  = (state_q == FETCH) & ~br_taken & credit_ok;
        imem_addr = fetch_pc_q;
        fs_valid  = ~buf_empty & ~br_taken;
        fs_pc     = buf_empty ? 32'h0 : buf_pc_q[rd_ptr_q];
        fs_instr  = buf_empty ? 32'h0 : buf_instr_q[rd_ptr_q];

        fire = imem_req & imem_gnt;
        drop = imem_rvalid & (drop_q != '0);
        push = imem_rvalid & ~drop & ~br_taken;
        pop  = fs_valid & fs_ready;

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            default: state_d = IDLE;
        endcase

        if (fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pcq_wr_d   = pcq_wr_q + PTR_W'(1);
        end
        if (imem_rvalid) begin
            pcq_rd_d = pcq_rd_q + PTR_W'(1);
        end
        out_d = out_q + CNT_W'(fire) - CNT_W'(imem_rvalid);

        if (drop) begin
            drop_d = drop_q - CNT_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

        // Redirect: everything already granted becomes a drop credit
        if (br_taken) begin
            fetch_pc_d = br_target & 32'hFFFF_FFFC;
            drop_d     = out_d;
            cnt_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counters
    always_ff @(posedge clk) begin
        if (fire) begin
            pcq_q[pcq_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            buf_pc_q[wr_ptr_q]    <= pcq_q[pcq_rd_q];
            buf_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
